// File: rtl/iter_int_mul_var.sv
// Iterative shift-add integer multiplier with val/rdy request and response
// handshakes, optional two's-complement operation and early termination once
// the remaining multiplier bits are all zero.
module iter_int_mul_var #(
  parameter int W         = 32,
  parameter bit SIGNED_EN = 1'b1,
  localparam int IW       = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_val,
  output logic            req_rdy,
  input  logic [W-1:0]    req_a,
  input  logic [W-1:0]    req_b,
  input  logic            req_signed,
  output logic            resp_val,
  input  logic            resp_rdy,
  output logic [2*W-1:0]  resp_p,
  output logic [IW-1:0]   resp_iters,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [1:0]       rst_sync;
  logic             rst_n;

  logic [2*W-1:0]   a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   p_q;
  logic [IW-1:0]    cnt_q;
  logic             sign_q;

  logic             signed_mode;
  logic             accept;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;

  // Unsigned magnitude of a W-bit operand; the most-negative value maps to
  // 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x,
                                             input logic                neg);
    logic [W-1:0] r;
    r = neg ? (~x + W'(1)) : x;
    return r;
  endfunction

  // Two's-complement negation of the product modulo 2^(2W).
  function automatic logic [2*W-1:0] negate_prod(input logic [2*W-1:0] p);
    logic [2*W-1:0] r;
    r = ~p + (2 * W)'(1);
    return r;
  endfunction

  // Reset asserts immediately, releases two clock edges after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign signed_mode = req_signed & SIGNED_EN;
  assign accept      = req_val & req_rdy;
  assign a_mag       = magnitude($signed(req_a), signed_mode & req_a[W-1]);
  assign b_mag       = magnitude($signed(req_b), signed_mode & req_b[W-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs; req_rdy is also gated by reset.
  always_comb begin
    state_next = state;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = rst_n;
        if (req_val && rst_n) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (b_q == '0) state_next = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        resp_val = 1'b1;
        if (resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, one shift-add per CALC cycle, and result finalisation
  // (sign fix-up and iteration count) on the cycle that finds B exhausted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      resp_p     <= '0;
      resp_iters <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= signed_mode & (req_a[W-1] ^ req_b[W-1]);
            a_q    <= {{W{1'b0}}, a_mag};
            b_q    <= b_mag;
            p_q    <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          if (b_q != '0) begin
            if (b_q[0]) p_q <= p_q + a_q;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + IW'(1);
          end else begin
            resp_p     <= sign_q ? negate_prod(p_q) : p_q;
            resp_iters <= cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_int_mul_var.sv
// Scoreboard bench for iter_int_mul_var at W=8, one instance with signed
// support and one with SIGNED_EN=0, sharing the stimulus bus.
module tb_iter_int_mul_var;

  localparam int W  = 8;
  localparam int IW = $clog2(W + 1);

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [IW-1:0]  it;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           req_val;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           req_signed;
  logic           resp_rdy;
  logic           sel;

  logic           val_s, rdy_s, rv_s, bz_s;
  logic           val_u, rdy_u, rv_u, bz_u;
  logic [2*W-1:0] p_s, p_u;
  logic [IW-1:0]  it_s, it_u;

  logic           rdy, rv, bz;
  logic [2*W-1:0] rp;
  logic [IW-1:0]  ri;

  exp_t           sb[$];
  int             passed;
  int             total;

  assign val_s = req_val & ~sel;
  assign val_u = req_val & sel;
  assign rdy   = sel ? rdy_u : rdy_s;
  assign rv    = sel ? rv_u  : rv_s;
  assign bz    = sel ? bz_u  : bz_s;
  assign rp    = sel ? p_u   : p_s;
  assign ri    = sel ? it_u  : it_s;

  iter_int_mul_var #(.W(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_val(val_s), .req_rdy(rdy_s),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .resp_val(rv_s), .resp_rdy(resp_rdy), .resp_p(p_s),
    .resp_iters(it_s), .busy(bz_s)
  );

  iter_int_mul_var #(.W(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .req_val(val_u), .req_rdy(rdy_u),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .resp_val(rv_u), .resp_rdy(resp_rdy), .resp_p(p_u),
    .resp_iters(it_u), .busy(bz_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input bit en, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit sg);
    exp_t        e;
    bit          s;
    longint      va, vb, prod;
    logic [W-1:0] mb;
    s    = sg & en;
    va   = s ? longint'($signed(a)) : longint'(a);
    vb   = s ? longint'($signed(b)) : longint'(b);
    prod = va * vb;
    e.p  = prod[2*W-1:0];
    mb   = (s && b[W-1]) ? W'(-vb) : b;
    e.it = '0;
    for (int i = 0; i < W; i++) if (mb[i]) e.it = IW'(i + 1);
    return e;
  endfunction

  task automatic send(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sg, output bit to);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy) begin to = 1'b0; break; end
    end
    sel        = s;
    req_a      = a;
    req_b      = b;
    req_signed = sg;
    req_val    = 1'b1;
    @(posedge clk);
    sb.push_back(model(s ? 1'b0 : 1'b1, a, b, sg));
    #1;
    req_val = 1'b0;
    req_a   = 8'hA5;
    req_b   = 8'h5A;
  endtask

  task automatic wait_resp(output int lat, output bit to, output bit bz_ok,
                           output logic [2*W-1:0] p, output logic [IW-1:0] it);
    lat   = 1;
    to    = 1'b1;
    bz_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bz) bz_ok = 1'b0;
      if (rv) begin to = 1'b0; break; end
      @(posedge clk);
      lat++;
    end
    p  = rp;
    it = ri;
  endtask

  task automatic handshake();
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++; if (rdy_s !== 1'b0) $display("FAIL reset_req_rdy: got %b want 0", rdy_s); else passed++;
    total++; if (rv_s !== 1'b0) $display("FAIL reset_resp_val: got %b want 0", rv_s); else passed++;
    total++; if (bz_s !== 1'b0) $display("FAIL reset_busy: got %b want 0", bz_s); else passed++;
    total++; if (p_s !== '0) $display("FAIL reset_resp_p: got %h want 0", p_s); else passed++;
    total++; if (it_s !== '0) $display("FAIL reset_resp_iters: got %h want 0", it_s); else passed++;
    total++; if (rdy_u !== 1'b0) $display("FAIL reset_req_rdy_u: got %b want 0", rdy_u); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned();
    bit to, bok; int lat; logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    send(1'b0, 8'd13, 8'd11, 1'b0, to);
    total++; if (to) $display("FAIL unsigned_accept: req_rdy never high"); else passed++;
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (to) $display("FAIL unsigned_timeout: no resp_val"); else passed++;
    total++; if (p !== e.p || p !== 16'h008F) $display("FAIL unsigned_p: got %h want 008f", p); else passed++;
    total++; if (it !== e.it || it !== 4'd4) $display("FAIL unsigned_iters: got %0d want 4", it); else passed++;
    total++; if (lat !== 6) $display("FAIL unsigned_latency: got %0d want 6", lat); else passed++;
    total++; if (!bok) $display("FAIL unsigned_busy: busy dropped before response"); else passed++;
    handshake();
    total++; if (bz !== 1'b0 || rdy !== 1'b1) $display("FAIL unsigned_idle: busy %b rdy %b want 0 1", bz, rdy); else passed++;
  endtask

  task automatic test_zero_mult();
    bit to, bok; int lat; logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    send(1'b0, 8'hFF, 8'h00, 1'b0, to);
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'h0000) $display("FAIL zero_p: got %h want 0000", p); else passed++;
    total++; if (it !== e.it || it !== 4'd0) $display("FAIL zero_iters: got %0d want 0", it); else passed++;
    total++; if (lat !== 2) $display("FAIL zero_latency: got %0d want 2", lat); else passed++;
    handshake();
  endtask

  task automatic test_worst_case();
    bit to, bok; int lat; logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    send(1'b0, 8'hFF, 8'hFF, 1'b0, to);
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'hFE01) $display("FAIL worst_p: got %h want fe01", p); else passed++;
    total++; if (it !== e.it || it !== 4'd8) $display("FAIL worst_iters: got %0d want 8", it); else passed++;
    total++; if (lat !== 10) $display("FAIL worst_latency: got %0d want 10", lat); else passed++;
    handshake();
  endtask

  task automatic test_signed();
    bit to, bok; int lat; logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    send(1'b0, 8'hFD, 8'h05, 1'b1, to);
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'hFFF1) $display("FAIL signed_p: got %h want fff1", p); else passed++;
    total++; if (it !== e.it || it !== 4'd3) $display("FAIL signed_iters: got %0d want 3", it); else passed++;
    handshake();
    send(1'b0, 8'h80, 8'h80, 1'b1, to);
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'h4000) $display("FAIL signed_min_p: got %h want 4000", p); else passed++;
    total++; if (it !== e.it || it !== 4'd8) $display("FAIL signed_min_iters: got %0d want 8", it); else passed++;
    handshake();
    send(1'b1, 8'h80, 8'h80, 1'b1, to);
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'h4000) $display("FAIL nosign_min_p: got %h want 4000", p); else passed++;
    handshake();
    send(1'b1, 8'hFD, 8'h05, 1'b1, to);
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'h04F1) $display("FAIL nosign_p: got %h want 04f1", p); else passed++;
    total++; if (it !== e.it || it !== 4'd3) $display("FAIL nosign_iters: got %0d want 3", it); else passed++;
    handshake();
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to, bok, stable_ok, rdy_ok, quiet_ok; int lat;
    logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    resp_rdy = 1'b0;
    send(1'b0, 8'd9, 8'd10, 1'b0, to);
    wait_resp(lat, to, bok, p, it);
    req_val   = 1'b1;
    req_a     = 8'd3;
    req_b     = 8'd5;
    stable_ok = 1'b1;
    rdy_ok    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rp !== p || rv !== 1'b1) stable_ok = 1'b0;
      if (rdy !== 1'b0) rdy_ok = 1'b0;
    end
    total++; if (!stable_ok) $display("FAIL bp_stable: resp_p %h resp_val %b want %h 1", rp, rv, p); else passed++;
    total++; if (!rdy_ok) $display("FAIL bp_req_rdy: req_rdy rose during DONE"); else passed++;
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'd90) $display("FAIL bp_p: got %h want %h", p, e.p); else passed++;
    req_val = 1'b0;
    handshake();
    total++; if (rv !== 1'b0 || bz !== 1'b0 || rdy !== 1'b1) $display("FAIL bp_idle: rv %b busy %b rdy %b want 0 0 1", rv, bz, rdy); else passed++;
    quiet_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rv || bz) quiet_ok = 1'b0;
    end
    total++; if (!quiet_ok) $display("FAIL bp_second_accept: activity after handshake"); else passed++;
  endtask

  task automatic test_reset_mid_calc();
    bit to, bok, quiet_ok; int lat; logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    resp_rdy = 1'b1;
    send(1'b0, 8'hFF, 8'hFF, 1'b0, to);
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++; if (rv !== 1'b0 || bz !== 1'b0 || rdy !== 1'b0) $display("FAIL rst_mid_outputs: rv %b busy %b rdy %b want 0 0 0", rv, bz, rdy); else passed++;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv) quiet_ok = 1'b0;
    end
    total++; if (!quiet_ok) $display("FAIL rst_mid_no_resp: resp_val after abort"); else passed++;
    send(1'b0, 8'd6, 8'd7, 1'b0, to);
    total++; if (to) $display("FAIL rst_mid_rdy: req_rdy never rose after release"); else passed++;
    wait_resp(lat, to, bok, p, it);
    e = sb.pop_front();
    total++; if (p !== e.p || p !== 16'd42) $display("FAIL rst_mid_p: got %0d want 42", p); else passed++;
    total++; if (it !== e.it || it !== 4'd3) $display("FAIL rst_mid_iters: got %0d want 3", it); else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    bit to, bok, s, sg; int lat; logic [2*W-1:0] p; logic [IW-1:0] it; exp_t e;
    logic [W-1:0] a, b;
    for (int n = 0; n < 8; n++) begin
      s  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      b  = W'($urandom);
      send(s, a, b, sg, to);
      wait_resp(lat, to, bok, p, it);
      e = sb.pop_front();
      total++; if (p !== e.p) $display("FAIL b2b_p[%0d]: a %h b %h s %b got %h want %h", n, a, b, sg, p, e.p); else passed++;
      total++; if (it !== e.it || lat !== int'(e.it) + 2) $display("FAIL b2b_iters[%0d]: got %0d lat %0d want %0d", n, it, lat, e.it); else passed++;
      handshake();
    end
    sel = 1'b0;
    total++; if (sb.size() !== 0) $display("FAIL scoreboard_left: got %0d want 0", sb.size()); else passed++;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    reset      = 1'b0;
    req_val    = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_signed = 1'b0;
    resp_rdy   = 1'b1;
    sel        = 1'b0;
    test_reset();
    test_unsigned();
    test_zero_mult();
    test_worst_case();
    test_signed();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iter_int_mul_var.md
# iter_int_mul_var

Parametrised iterative integer multiplier with an integrated datapath, val/rdy request and response interfaces, optional signed operation, and early termination. Each cycle it shifts and adds one multiplier bit, and it stops as soon as the remaining multiplier bits are zero, so latency depends on the operand. It is the next-generation multiply unit for the execute stage and replaces the fixed 8-iteration controller plus external datapath arrangement.

## Interface
- `W`, default 32: operand width, ≥2; product is 2W bits.
- `SIGNED_EN`, default 1: 1 honours `req_signed`; 0 forces unsigned operation.
- `clk` in, 1: clock; all state updates on its rising edge.
- `reset` in, 1: asynchronous, active-low reset; state clears as soon as it goes low, and release is synchronised to `clk`.
- `req_val` in, 1: request valid.
- `req_rdy` out, 1: request ready.
- `req_a` in, W: multiplicand.
- `req_b` in, W: multiplier.
- `req_signed` in, 1: 1 means the operands are two's-complement.
- `resp_val` out, 1: response valid.
- `resp_rdy` in, 1: consumer ready.
- `resp_p` out, 2W: product.
- `resp_iters` out, clog2(W+1): number of add/shift iterations performed.
- `busy` out, 1: high in CALC or DONE.

## Operation
- States:
  - IDLE: `req_rdy`=1.
  - CALC: one iteration per cycle.
  - DONE: `resp_val`=1.
- Accept occurs on a cycle with `req_val` and `req_rdy` both high. On accept:
  - sign register = `req_signed`&SIGNED_EN & (a[W-1]^b[W-1]);
  - A (2W bits) = |a| zero-extended;
  - B (W bits) = |b|;
  - P = 0; iteration count = 0; next state CALC.
- Magnitudes are taken only when signed mode is active and the operand MSB is 1. The magnitude of the most-negative value, 2^(W-1), fits W bits unsigned.
- CALC with B≠0, per cycle:
  - if B[0]=1, P ← P+A (2W bits, no overflow possible);
  - A ← A<<1; B ← B>>1; count ← count+1.
- CALC with B=0: P ← sign ? (−P mod 2^2W) : P; `resp_iters` ← count; next state DONE. No accumulate happens in this cycle.
- DONE: `resp_p` and `resp_iters` hold stable. On `resp_val`&`resp_rdy`, go to IDLE.
- Requests are never overlapped: `req_rdy`=0 in CALC and DONE, and `req_val` is ignored there.
- `resp_p`/`resp_iters` keep their last values in IDLE; only DONE gives them meaning.
- Operands are registered at accept. Later changes on `req_a`/`req_b` have no effect.

## Timing
- Reset low, asynchronously: state IDLE, `req_rdy`=0, `resp_val`=0, `busy`=0, `resp_p`=0, `resp_iters`=0, A/B/P/count/sign=0.
- `req_rdy` is gated by reset: it rises only when reset is high and the state is IDLE.
- Let k = index of the highest set bit of |b| + 1 (k=0 when b=0); k ≤ W.
- If accept happens at edge t:
  - CALC occupies cycles t..t+k (k+1 cycles);
  - `resp_val` rises after edge t+k+1;
  - `resp_iters` = k.
- Best case: b=0, `resp_val` 2 cycles after accept. Worst case: k=W, W+2 cycles.
- After a response handshake at edge u, `req_rdy` is high after u. This gives a minimum initiation interval of k+3 cycles.
- If `resp_rdy` is low, the block stalls in DONE indefinitely with outputs stable.
- Reset asserted mid-CALC or mid-DONE aborts the operation. The result is lost and no response is issued. After release, the first accept is at the earliest on the first edge where `req_rdy`=1.
- Signed boundary: (−2^(W-1))·(−2^(W-1)) = 2^(2W-2), which is representable.
- When SIGNED_EN=0, `req_signed` is don't-care.

## Test plan
- Unsigned, W=8: a=13, b=11.
  - Required: `resp_p`=143 (0x008F), `resp_iters`=4, `resp_val` 6 cycles after accept.
  - Also: `busy` high from accept through the response handshake.
- Zero multiplier: a=0xFF, b=0.
  - Required: `resp_p`=0, `resp_iters`=0, `resp_val` 2 cycles after accept.
- Unsigned worst case: a=b=0xFF.
  - Required: `resp_p`=0xFE01, `resp_iters`=8, `resp_val` 10 cycles after accept.
- Signed: a=0xFD (−3), b=0x05.
  - Required: `resp_p`=0xFFF1, `resp_iters`=3.
  - Also: a=b=0x80 gives 0x4000 with `resp_iters`=8.
  - With SIGNED_EN=0, a=b=0x80 gives 0x4000 as well.
  - With SIGNED_EN=0, a=0xFD, b=0x05 gives 0x04F1.
- Backpressure: hold `resp_rdy`=0 for 5 cycles in DONE while `req_val`=1 with new operands.
  - Required: `resp_p` stable and `req_rdy`=0 throughout, and no second accept.
  - Required: after `resp_rdy`=1, one handshake, then IDLE.
- Reset mid-CALC: pull reset low at cycle 2 of an a=0xFF, b=0xFF operation.
  - Required: `resp_val`/`busy`/`req_rdy` go to 0 immediately and no response ever appears.
  - Required: after release, a=6, b=7 yields 42 with `resp_iters`=3.
